sub_div_opr: RTL and testbench
==============================

// Module: sub_div_opr
// PURPOSE
//  Multicycle shift-and-subtract (restoring) divider for the ALU's DIV/DIVU path.
//  Inverse companion of the ripple-carry adder: each step forms a trial
//  difference as a + ~b + 1 and keeps it only if no borrow occurs.
//  Produces quotient (to LO) and remainder (to HI). Signed and unsigned modes.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; iteration count equals WIDTH
// PORTS
//  clk          in   1      rising-edge clock, the only clock
//  rst          in   1      synchronous, active-high reset
//  start        in   1      request; operands sampled when accepted
//  is_signed    in   1      1 = DIV (two's complement), 0 = DIVU
//  a            in   WIDTH  dividend
//  b            in   WIDTH  divisor
//  busy         out  1      1 while an operation is in progress
//  done         out  1      one-cycle pulse: results valid
//  quo          out  WIDTH  quotient, held until next accepted start
//  rem          out  WIDTH  remainder, held until next accepted start
//  div_by_zero  out  1      set with done when b == 0; held with results
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, quo=0, rem=0, div_by_zero=0.
//  FSM: IDLE -> RUN on accepted start (b!=0); IDLE -> FIN on accepted start (b==0);
//   RUN -> FIN after WIDTH iterations; FIN -> IDLE unconditionally.
//  start is accepted only in IDLE. While busy=1 it is ignored; no queueing.
//  Accept cycle: latch |a|, |b|, sign of quotient (a[MSB]^b[MSB]) and sign of a
//   when is_signed=1; raw values otherwise. Iteration counter loads WIDTH.
//  RUN, one bit per cycle: P={R,Q}<<1; D=P_hi - B (computed as P_hi + ~B + 1);
//   if carry-out=1 (no borrow): R=D, Q[0]=1; else R=P_hi, Q[0]=0. Counter decrements.
//  FIN: apply signs (negate Q if quotient sign set, negate R if dividend negative),
//   write quo/rem, done=1 for this cycle only, busy=0 in FIN.
//  Latency: start accepted at edge N -> busy=1 for edges N+1..N+WIDTH ->
//   done=1 in the cycle following edge N+WIDTH+1 (WIDTH+1 cycles start-to-done).
//  Remainder always takes the sign of the dividend; quotient truncates to zero.
//  Divide by zero: skips RUN; FIN gives quo=all ones, rem=a, div_by_zero=1;
//   done 1 cycle after start. div_by_zero clears on next accepted start.
//  Overflow (signed MIN / -1): quo=MIN (0x80000000), rem=0, no flag.
//  Internal magnitude registers are WIDTH+1 bits so |MIN| is representable.
//  rst mid-operation: next edge returns to IDLE, all outputs to reset values,
//   no done pulse for the aborted operation.
//  start asserted in the same cycle as rst: rst wins, request dropped.
//  quo/rem/div_by_zero change only in FIN or on reset.
// CONFIGURATION
//  SUB_DIV_EARLY_EXIT_EN defined: at accept, if |b| > |a| (unsigned compare of
//   magnitudes), skip RUN and go to FIN with Q=0, R=|a|; done 1 cycle after start.
//   Also applies to a == 0.
//  Not defined: every non-zero-divisor operation takes exactly WIDTH+1 cycles.
// TESTING
//  DIVU a=100 b=7 -> quo=14, rem=2, div_by_zero=0, done exactly 33 cycles after start.
//  DIV a=0xFFFFFFF9(-7) b=2 -> quo=0xFFFFFFFD(-3), rem=0xFFFFFFFF(-1).
//  DIV a=0x80000000 b=0xFFFFFFFF -> quo=0x80000000, rem=0, div_by_zero=0.
//  DIVU a=5 b=0 -> div_by_zero=1, quo=0xFFFFFFFF, rem=5, done 1 cycle after start.
//  DIVU 0xFFFFFFFF/1, then start pulsed at busy cycle 5 with a=9 b=3 -> only
//   quo=0xFFFFFFFF rem=0 reported; single done pulse.
//  rst asserted 10 cycles into a DIVU 1000/3 -> next cycle busy=0, quo=rem=0,
//   no done; fresh DIVU 1000/3 afterwards -> quo=333, rem=1.
//  With SUB_DIV_EARLY_EXIT_EN: DIVU 3/10 -> quo=0, rem=3, done 1 cycle after start.

Source files
------------

// File: rtl/sub_div_opr.sv
// Multicycle restoring divider (DIV/DIVU): quotient to quo, remainder to rem.
// Optional SUB_DIV_EARLY_EXIT_EN: finish immediately when |b| > |a|.
module sub_div_opr #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             div_by_zero
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t state, state_nx;

    logic [WIDTH:0]   b_q;
    logic [WIDTH-1:0] r_q, q_q;
    logic [CW-1:0]    cnt;
    logic             qneg, aneg, zero;

    logic [WIDTH-1:0] abs_a;
    logic [WIDTH:0]   abs_b;
    logic             b_zero, early;
    logic [WIDTH:0]   p_hi, d;
    logic             carry;
    logic [WIDTH-1:0] r_nxt;
    logic             unused_d_msb;

    assign abs_a  = (is_signed && a[WIDTH-1]) ? -a : a;
    assign abs_b  = {1'b0, (is_signed && b[WIDTH-1]) ? -b : b};
    assign b_zero = (b == '0);

`ifdef SUB_DIV_EARLY_EXIT_EN
    assign early = !b_zero && (abs_b > {1'b0, abs_a});
`else
    assign early = 1'b0;
`endif

    // Trial subtraction P_hi - B done as P_hi + ~B + 1; carry-out means no borrow.
    assign p_hi           = {r_q, q_q[WIDTH-1]};
    assign {carry, d}     = {1'b0, p_hi} + {1'b0, ~b_q} + {{(WIDTH+1){1'b0}}, 1'b1};
    assign r_nxt          = carry ? d[WIDTH-1:0] : p_hi[WIDTH-1:0];
    assign unused_d_msb   = d[WIDTH];

    assign busy = (state == RUN);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = (b_zero || early) ? FIN : RUN;
            RUN:  if (cnt == CW'(1)) state_nx = FIN;
            FIN:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            done        <= 1'b0;
            quo         <= '0;
            rem         <= '0;
            div_by_zero <= 1'b0;
            b_q         <= '0;
            r_q         <= '0;
            q_q         <= '0;
            cnt         <= '0;
            qneg        <= 1'b0;
            aneg        <= 1'b0;
            zero        <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == FIN);
            case (state)
                IDLE: if (start) begin
                    qneg        <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    aneg        <= is_signed & a[WIDTH-1];
                    zero        <= b_zero;
                    div_by_zero <= 1'b0;
                    cnt         <= CW'(WIDTH);
                    b_q         <= abs_b;
                    r_q         <= '0;
                    q_q         <= abs_a;
                    // Divide by zero keeps the raw dividend around for rem.
                    if (b_zero) begin
                        q_q <= a;
                    end else if (early) begin
                        r_q <= abs_a;
                        q_q <= '0;
                    end
                end
                RUN: begin
                    r_q <= r_nxt;
                    q_q <= {q_q[WIDTH-2:0], carry};
                    cnt <= cnt - CW'(1);
                end
                FIN: begin
                    quo         <= zero ? '1  : (qneg ? -q_q : q_q);
                    rem         <= zero ? q_q : (aneg ? -r_q : r_q);
                    div_by_zero <= zero;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_sub_div_opr.sv
// Scoreboard bench for sub_div_opr: expected results queued at start, checked on done.
module tb_sub_div_opr;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, is_signed;
    logic [W-1:0] a, b;
    logic         busy, done, dbz;
    logic [W-1:0] quo, rem;

    always #5 clk = ~clk;

    sub_div_opr #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
        .a(a), .b(b), .busy(busy), .done(done),
        .quo(quo), .rem(rem), .div_by_zero(dbz)
    );

    typedef struct {
        logic [W-1:0] quo;
        logic [W-1:0] rem;
        logic         dbz;
        int           lat;
        int           t0;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    int   ndone  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        logic signed [W-1:0] sx, sy;
        logic [W-1:0] mx, my;
        sx = x; sy = y;
        e.dbz = 1'b0; e.lat = W + 1; e.t0 = 0;
        mx = (s && x[W-1]) ? -x : x;
        my = (s && y[W-1]) ? -y : y;
        if (y == 0) begin
            e.quo = '1; e.rem = x; e.dbz = 1'b1; e.lat = 1;
        end else if (s) begin
            if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
                e.quo = x; e.rem = '0;
            end else begin
                e.quo = sx / sy; e.rem = sx % sy;
            end
        end else begin
            e.quo = x / y; e.rem = x % y;
        end
`ifdef SUB_DIV_EARLY_EXIT_EN
        if (y != 0 && my > mx) e.lat = 1;
`else
        if (mx == my && mx == 0) e.lat = 1;
`endif
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            ndone++;
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                e = sb.pop_front();
                check("quo", quo, e.quo);
                check("rem", rem, e.rem);
                check("dbz", dbz, e.dbz);
                check("latency", cyc - e.t0, e.lat);
            end
        end
    end

    task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        exp_t e;
        int n = 0;
        while ((busy || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("op_timeout", 1, 0);
        a = x; b = y; is_signed = s; start = 1'b1;
        e = model(x, y, s);
        e.t0 = cyc + 1;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((busy || done || sb.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("drain_timeout", 1, 0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n0;
        logic [W-1:0] x, y;
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_quo", quo, 0);
        check("rst_rem", rem, 0);
        check("rst_dbz", dbz, 0);
        rst = 1'b0;
        @(negedge clk);

        op(32'd100, 32'd7, 1'b0);
        op(32'hFFFF_FFF9, 32'd2, 1'b1);
        op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        op(32'd5, 32'd0, 1'b0);
        op(32'd3, 32'd10, 1'b0);
        op(32'd0, 32'd9, 1'b1);
        op(32'd7, 32'hFFFF_FFFE, 1'b1);
        drain();

        // Start pulsed while busy must be dropped.
        n0 = ndone;
        op(32'hFFFF_FFFF, 32'd1, 1'b0);
        repeat (4) @(negedge clk);
        check("busy_mid", busy, 1);
        a = 32'd9; b = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();
        repeat (40) @(negedge clk);
        check("single_done", ndone - n0, 1);

        // Reset ten cycles into an operation aborts it silently.
        a = 32'd1000; b = 32'd3; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_quo", quo, 0);
        check("abort_rem", rem, 0);
        check("abort_done", done, 0);
        rst = 1'b0;
        n0 = ndone;
        repeat (40) @(negedge clk);
        check("abort_no_done", ndone - n0, 0);
        op(32'd1000, 32'd3, 1'b0);
        drain();

        // Start together with reset is dropped.
        n0 = ndone;
        a = 32'd10; b = 32'd2; start = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        check("rst_start_busy", busy, 0);
        repeat (40) @(negedge clk);
        check("rst_start_no_done", ndone - n0, 0);

        for (int i = 0; i < 20; i++) begin
            x = $urandom;
            y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 15)) : $urandom;
            if (i % 7 == 3) x = 32'($urandom_range(0, 20));
            if (i == 11) y = '0;
            op(x, y, 1'($urandom_range(0, 1)));
        end
        drain();
        check("sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
